// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave shifters: beat counter type, command
// target and the word-length saturation helper.
package spi_slave_pkg;

  localparam int SPI_CNT_W = 8;

  typedef logic [SPI_CNT_W-1:0] spi_cnt_t;

  localparam spi_cnt_t SPI_CMD_TRGT = 8'h07;

  // Clamp a requested target (beats minus one) to what the word can hold.
  function automatic spi_cnt_t spi_sat_trgt(input spi_cnt_t req, input int cap);
    spi_sat_trgt = (int'(req) > cap) ? spi_cnt_t'(cap) : req;
  endfunction

endpackage

// File: rtl/spi_slave_rx.sv
// SPI slave receive shifter: assembles MSB-first words of programmable length on sclk.
// Define SPI_RX_QUAD_EN to add the sdi1..sdi3 / en_quad_in ports and nibble-wide beats.
module spi_slave_rx
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  sdi0,
`ifdef SPI_RX_QUAD_EN
  input  logic                  sdi1,
  input  logic                  sdi2,
  input  logic                  sdi3,
  input  logic                  en_quad_in,
`endif
  input  logic [SPI_CNT_W-1:0]  counter_in,
  input  logic                  counter_in_upd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_ready
);

  localparam int CAP_SINGLE = DATA_WIDTH - 1;

  spi_cnt_t              counter_q, counter_d;
  spi_cnt_t              counter_trgt_q, counter_trgt_d;
  logic [DATA_WIDTH-1:0] data_int_q, data_int_d;
  logic                  data_ready_q, data_ready_d;
  logic [DATA_WIDTH-1:0] beat;
  logic [DATA_WIDTH-1:0] shifted;
  spi_cnt_t              trgt_new;

`ifdef SPI_RX_QUAD_EN
  localparam int CAP_QUAD = DATA_WIDTH / 4 - 1;

  logic quad_q, quad_d;

  always_comb begin
    beat = '0;
    if (quad_q) begin
      beat[3:0] = {sdi3, sdi2, sdi1, sdi0};
      shifted   = {data_int_q[DATA_WIDTH-5:0], 4'b0000};
    end else begin
      beat[0]   = sdi0;
      shifted   = {data_int_q[DATA_WIDTH-2:0], 1'b0};
    end
    trgt_new = spi_sat_trgt(counter_in, en_quad_in ? CAP_QUAD : CAP_SINGLE);
    quad_d   = counter_in_upd ? en_quad_in : quad_q;
  end
`else
  always_comb begin
    beat     = '0;
    beat[0]  = sdi0;
    shifted  = {data_int_q[DATA_WIDTH-2:0], 1'b0};
    trgt_new = spi_sat_trgt(counter_in, CAP_SINGLE);
  end
`endif

  always_comb begin
    counter_d      = counter_q;
    counter_trgt_d = counter_trgt_q;
    data_ready_d   = 1'b0;
    // The first beat of a word starts fresh so the previous word never leaks in.
    data_int_d     = (counter_q == '0) ? beat : (shifted | beat);
    if (counter_q == counter_trgt_q) begin
      counter_d    = '0;
      data_ready_d = 1'b1;
    end else begin
      counter_d    = counter_q + spi_cnt_t'(1);
    end
    if (counter_in_upd) begin
      counter_trgt_d = trgt_new;
    end
  end

  always_ff @(posedge sclk) begin
    if (cs) begin
      counter_q      <= '0;
      counter_trgt_q <= SPI_CMD_TRGT;
      data_int_q     <= '0;
      data_ready_q   <= 1'b0;
`ifdef SPI_RX_QUAD_EN
      quad_q         <= 1'b0;
`endif
    end else begin
      counter_q      <= counter_d;
      counter_trgt_q <= counter_trgt_d;
      data_int_q     <= data_int_d;
      data_ready_q   <= data_ready_d;
`ifdef SPI_RX_QUAD_EN
      quad_q         <= quad_d;
`endif
    end
  end

  assign data       = data_int_q;
  assign data_ready = data_ready_q;

endmodule
